// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the trainable perceptron: FSM states,
// derived width calculators and a width-generic signed saturating add.
package perceptron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  function automatic int calc_a_w(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  function automatic int calc_acc_w(input int n_in, input int w_width);
    return w_width + $clog2(n_in + 1) + 1;
  endfunction

  // Result is clamped to the signed range of a w_width-bit value; the caller
  // truncates the 32-bit return to w_width bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] w,
                                                 input logic signed [31:0] delta,
                                                 input int w_width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] s;
    hi = (32'sd1 <<< (w_width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w_width - 1));
    s  = w + delta;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/perceptron_weight_bank.sv
// Storage for N_IN signed weights plus the bias (entry N_IN), with a host
// config port and an indexed read / saturating-update port for the core FSM.
module perceptron_weight_bank
  import perceptron_pkg::*;
#(
  parameter int N_IN        = 7,
  parameter int W_WIDTH     = 8,
  parameter int WEIGHT_INIT = 64,
  parameter int STEP        = 1,
  parameter int A_W         = calc_a_w(N_IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [A_W-1:0]            cfg_addr,
  input  logic signed [W_WIDTH-1:0] cfg_wdata,
  output logic signed [W_WIDTH-1:0] cfg_rdata,
  input  logic [A_W-1:0]            idx,
  output logic signed [W_WIDTH-1:0] rd_weight,
  output logic signed [W_WIDTH-1:0] bias,
  input  logic                      upd_en,
  input  logic                      upd_up
);

  localparam int N_ENT = N_IN + 1;

  logic signed [W_WIDTH-1:0] mem [N_ENT];
  logic                      cfg_hit;
  logic                      idx_hit;
  logic signed [31:0]        delta;

  assign cfg_hit   = int'(cfg_addr) <= N_IN;
  assign idx_hit   = int'(idx) <= N_IN;
  assign delta     = upd_up ? STEP : -STEP;
  assign rd_weight = idx_hit ? mem[idx] : '0;
  assign bias      = mem[N_IN];

  // Host writes and learning updates never coincide: the core only
  // forwards cfg_we while idle and only raises upd_en while updating.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) mem[i] <= W_WIDTH'(WEIGHT_INIT);
      mem[N_IN] <= '0;
      cfg_rdata <= '0;
    end else begin
      cfg_rdata <= cfg_hit ? mem[cfg_addr] : '0;
      if (cfg_we && cfg_hit) begin
        mem[cfg_addr] <= cfg_wdata;
      end else if (upd_en && idx_hit) begin
        mem[idx] <= W_WIDTH'(sat_add(32'(mem[idx]), delta, W_WIDTH));
      end
    end
  end

endmodule

// File: rtl/perceptron_trainable.sv
// Bit-serial trainable perceptron: serial weighted sum, bias, threshold
// decision, and an optional perceptron-rule update on misclassification.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | in_ready high; accepts a sample and host config writes
// ST_ACCUM  | one input per cycle, adds weight[k] when x[k] is set
// ST_DECIDE | registers sum/class, pulses out_valid (and out_updated)
// ST_UPDATE | one weight per cycle, then the bias, saturating +/-STEP
module perceptron_trainable
  import perceptron_pkg::*;
#(
  parameter int N_IN        = 7,
  parameter int W_WIDTH     = 8,
  parameter int THRESHOLD   = 64,
  parameter int WEIGHT_INIT = 64,
  parameter int STEP        = 1,
  parameter int ACC_W       = calc_acc_w(N_IN, W_WIDTH),
  parameter int A_W         = calc_a_w(N_IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           in_x,
  input  logic                      in_label,
  input  logic                      in_train,
  output logic                      out_valid,
  output logic                      out_class,
  output logic signed [ACC_W-1:0]   out_sum,
  output logic                      out_updated,
  input  logic                      cfg_we,
  input  logic [A_W-1:0]            cfg_addr,
  input  logic signed [W_WIDTH-1:0] cfg_wdata,
  output logic signed [W_WIDTH-1:0] cfg_rdata
);

  localparam logic [A_W-1:0] K_LAST = A_W'(N_IN - 1);
  localparam logic [A_W-1:0] K_BIAS = A_W'(N_IN);

  state_t                    state, state_nx;
  logic [A_W-1:0]            k;
  logic [N_IN-1:0]           x_q;
  logic                      label_q;
  logic                      train_q;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum_c;
  logic                      class_c;
  logic                      mis_c;
  logic                      accept;
  logic                      upd_en;
  logic                      bank_we;
  logic signed [W_WIDTH-1:0] rd_weight;
  logic signed [W_WIDTH-1:0] bias;

  assign accept  = in_valid & in_ready;
  assign bank_we = cfg_we & (state == ST_IDLE);
  assign sum_c   = acc + ACC_W'(bias);
  assign class_c = int'(sum_c) >= THRESHOLD;
  assign mis_c   = train_q & (class_c != label_q);

  perceptron_weight_bank #(
    .N_IN       (N_IN),
    .W_WIDTH    (W_WIDTH),
    .WEIGHT_INIT(WEIGHT_INIT),
    .STEP       (STEP),
    .A_W        (A_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (bank_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .idx      (k),
    .rd_weight(rd_weight),
    .bias     (bias),
    .upd_en   (upd_en),
    .upd_up   (label_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    upd_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (k == K_LAST) state_nx = ST_DECIDE;
      end
      ST_DECIDE: begin
        state_nx = mis_c ? ST_UPDATE : ST_IDLE;
      end
      ST_UPDATE: begin
        if (k == K_BIAS) begin
          upd_en   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          upd_en = x_q[k];
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // k walks the inputs in ACCUM, then restarts to walk weights+bias in UPDATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= '0;
      x_q         <= '0;
      label_q     <= 1'b0;
      train_q     <= 1'b0;
      acc         <= '0;
      out_valid   <= 1'b0;
      out_updated <= 1'b0;
      out_class   <= 1'b0;
      out_sum     <= '0;
    end else begin
      out_valid   <= 1'b0;
      out_updated <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_q     <= in_x;
            label_q <= in_label;
            train_q <= in_train;
            acc     <= '0;
            k       <= '0;
          end
        end
        ST_ACCUM: begin
          if (x_q[k]) acc <= acc + ACC_W'(rd_weight);
          k <= k + 1'b1;
        end
        ST_DECIDE: begin
          out_valid   <= 1'b1;
          out_sum     <= sum_c;
          out_class   <= class_c;
          out_updated <= mis_c;
          k           <= '0;
        end
        ST_UPDATE: begin
          k <= k + 1'b1;
        end
        default: k <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainable.sv
// Directed bench for perceptron_trainable: the driver queues expected results,
// a negedge monitor pops and checks them whenever out_valid pulses.
module tb_perceptron_trainable;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_x;
  logic        in_label;
  logic        in_train;
  logic        out_valid;
  logic        out_class;
  logic [11:0] out_sum;
  logic        out_updated;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  cfg_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [11:0] sum;
    logic        cls;
    logic        upd;
    int          hs;
  } exp_t;

  exp_t exp_q[$];

  perceptron_trainable dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_label   (in_label),
    .in_train   (in_train),
    .out_valid  (out_valid),
    .out_class  (out_class),
    .out_sum    (out_sum),
    .out_updated(out_updated),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual_sum=%0d required=none", out_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_class", 32'(out_class), 32'(e.cls));
        chk("out_updated", 32'(out_updated), 32'(e.upd));
        chk("out_latency", cyc - e.hs, 8);
      end
    end
  end

  task automatic launch(input logic [6:0] x, input logic lbl, input logic trn,
                        input int esum, input logic ecls, input logic eupd,
                        input logic we, input logic [2:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL launch_ready_timeout actual=0 required=1");
      return;
    end
    in_x      = x;
    in_label  = lbl;
    in_train  = trn;
    in_valid  = 1'b1;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = d;
    exp_q.push_back('{sum: 12'(esum), cls: ecls, upd: eupd, hs: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int exp_low);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, exp_low);
  endtask

  task automatic send(input logic [6:0] x, input logic lbl, input logic trn,
                      input int esum, input logic ecls, input logic eupd);
    launch(x, lbl, trn, esum, ecls, eupd, 1'b0, 3'd0, 8'd0);
    wait_idle("busy_cycles", eupd ? 16 : 8);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string nm, input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    cfg_addr = a;
    @(negedge clk);
    chk(nm, 32'(cfg_rdata), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_label = 1'b0; in_train = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_cfg_rdata", 32'(cfg_rdata), 0);

    // Plain inference with reset weights (all 64, bias 0).
    send(7'b0000000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(7'b0000001, 1'b0, 1'b0, 64, 1'b1, 1'b0);
    send(7'b1111111, 1'b0, 1'b0, 448, 1'b1, 1'b0);
    send(7'b1010101, 1'b0, 1'b0, 256, 1'b1, 1'b0);

    // Misclassified positive sample nudges w0 and bias up by one.
    cfg_write(3'd0, 8'h80);
    send(7'b0000001, 1'b1, 1'b1, -128, 1'b0, 1'b1);
    cfg_read("upd_w0", 3'd0, 8'h81);
    cfg_read("upd_bias", 3'd7, 8'h01);
    cfg_read("upd_w1_untouched", 3'd1, 8'd64);

    // Saturation at the negative bias rail.
    cfg_write(3'd0, 8'd127);
    cfg_write(3'd1, 8'd127);
    cfg_write(3'd7, 8'h80);
    send(7'b0000011, 1'b0, 1'b1, 126, 1'b1, 1'b1);
    cfg_read("sat_w0", 3'd0, 8'd126);
    cfg_read("sat_w1", 3'd1, 8'd126);
    cfg_read("sat_bias", 3'd7, 8'h80);

    // Training enabled but correctly classified: no update.
    send(7'b0000011, 1'b1, 1'b1, 124, 1'b1, 1'b0);

    // Reset partway through ACCUM aborts without a result.
    @(negedge clk);
    in_x = 7'b1111111; in_train = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    cfg_read("abort_w0", 3'd0, 8'd64);
    cfg_read("abort_w1", 3'd1, 8'd64);
    cfg_read("abort_bias", 3'd7, 8'd0);

    // Config write during ACCUM is dropped.
    launch(7'b0000000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 8'd5;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_idle("busy_cycles_wr", 7);
    cfg_read("drop_w2", 3'd2, 8'd64);
    send(7'b0000100, 1'b0, 1'b0, 64, 1'b1, 1'b0);

    // Write coinciding with the handshake is used by that same sample.
    launch(7'b0001000, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b1, 3'd3, 8'd10);
    wait_idle("busy_cycles_sim", 8);
    cfg_read("sim_w3", 3'd3, 8'd10);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/perceptron_trainable.md
Name: perceptron_trainable

Overview:
Parametrised, trainable successor to the bit-serial perceptron. It accepts an N_IN-bit binary feature vector over a valid/ready handshake and walks the inputs serially, one per cycle, accumulating signed weights. It then adds a signed bias and compares the result against a threshold. In training mode it applies the perceptron learning rule on a misclassification. Weights and bias are host-loadable and readable through a small config port.

Parameters:
- N_IN, 7, number of binary inputs (>=2)
- W_WIDTH, 8, signed two's-complement width of each weight and of the bias
- THRESHOLD, 64, signed decision threshold: class = (sum + bias >= THRESHOLD)
- WEIGHT_INIT, 64, reset value of every weight (bias resets to 0)
- STEP, 1, magnitude of each learning-rule increment
- ACC_W, derived = W_WIDTH + $clog2(N_IN+1) + 1, accumulator width; wide enough that it never overflows
- A_W, derived = $clog2(N_IN+1), config address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  feature vector valid
- in_ready  out  1  high only in IDLE
- in_x  in  N_IN  feature bits; bit k multiplies weight k
- in_label  in  1  target class, used only when in_train=1
- in_train  in  1  enable learning for this sample
- out_valid  out  1  one-cycle pulse; result valid
- out_class  out  1  classification, held until next out_valid
- out_sum  out  ACC_W  signed sum + bias, held with out_class
- out_updated  out  1  one-cycle pulse, asserted with out_valid when an update will follow
- cfg_we  in  1  config write strobe
- cfg_addr  in  A_W  0..N_IN-1 = weight k; N_IN = bias; higher addresses ignored
- cfg_wdata  in  W_WIDTH  write data
- cfg_rdata  out  W_WIDTH  registered read of the entry at cfg_addr; 1-cycle latency; reads 0 for out-of-range addresses

Behaviour:
- Reset (rst=1 at posedge): FSM to IDLE; all weights = WEIGHT_INIT; bias = 0; accumulator = 0. out_valid, out_updated, out_class, out_sum and cfg_rdata all = 0. Reset during any state aborts the operation; no out_valid is produced.
- FSM states: IDLE, ACCUM, DECIDE, UPDATE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) captures in_x, in_label and in_train, clears the accumulator, sets index k=0, and moves to ACCUM.
- ACCUM: one cycle per input. If x[k]=1, acc += sign-extended weight[k]. After k = N_IN-1, go to DECIDE. Total N_IN cycles.
- DECIDE, single cycle:
  - out_sum <= acc + bias; out_class <= (acc + bias >= THRESHOLD); out_valid pulses.
  - out_valid therefore rises N_IN+1 cycles after the accepting edge.
  - If in_train=1 and out_class != label: pulse out_updated and go to UPDATE.
  - Otherwise return to IDLE.
- UPDATE: error e = +1 if label=1, else -1.
  - One weight per cycle, k = 0..N_IN-1: if x[k]=1, weight[k] += e*STEP.
  - Then one further cycle: bias += e*STEP.
  - Total N_IN+1 cycles, then IDLE.
  - Every update saturates to the range [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1]; no wrap.
- Config writes: accepted only in IDLE. A write in any other state is dropped silently.
- Simultaneous cfg_we and input handshake in IDLE: the write commits at the same edge and is used by the accumulation that starts on the next cycle.
- Config reads are legal in every state; during UPDATE they show the value before or after the update depending on the cycle.
- No backpressure on the output. Back-to-back samples: in_ready reasserts on the cycle after DECIDE, or after UPDATE when an update ran.

Decomposition:
- perceptron_pkg holds:
  - the state enum
  - ACC_W / A_W derivation functions
  - a signed saturating add function sat_add(w, delta, W_WIDTH)
- One sub-module: perceptron_weight_bank. It holds the N_IN weights plus the bias, with a config write port, a registered config read port, an indexed combinational read for ACCUM, and an indexed saturating increment/decrement for UPDATE.

Test Plan (defaults N_IN=7, W_WIDTH=8, THRESHOLD=64, WEIGHT_INIT=64):
1. Reset, then in_x=0000000, train=0 -> out_valid 8 cycles after handshake; out_sum=0; out_class=0; out_updated=0.
2. in_x=0000001 -> out_sum=64, class=1. Then in_x=1111111 -> out_sum=448 (no overflow at ACC_W=12), class=1.
3. cfg write w0=-128; in_x=0000001, train=1, label=1 -> class 0, out_updated=1. Afterwards readback gives w0=-127 (addr 0) and bias=1 (addr 7), with 1-cycle rdata latency. in_ready stays low for 8 UPDATE cycles.
4. Saturation: set w0=w1=127 and bias=-128; in_x=0000011, train=1, label=0 -> out_sum=126, class=1. Afterwards w0=w1=126 and bias stays -128 (saturated).
5. Reset asserted 3 cycles into ACCUM -> no out_valid; next cycle in_ready=1 and weights back to 64.
6. cfg_we with w2=5 during ACCUM -> ignored; readback of w2=64; the next sample using bit 2 sums 64.
